// File: rtl/register_file_rename_pkg.sv
// Shared definitions for the rename register file and the reorder buffer.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package register_file_rename_pkg;

    localparam int ROB_WIDTH = 4;            // ROB tag width, shared with the reorder buffer
    localparam int REG_COUNT = 32;           // architectural registers, x0 hardwired zero
    localparam int REG_IDX_W = 5;            // architectural register index width
    localparam int XLEN      = 32;           // register value width

    typedef logic [ROB_WIDTH-1:0] rob_tag_t;
    typedef logic [REG_IDX_W-1:0] reg_idx_t;
    typedef logic [XLEN-1:0]      word_t;

endpackage

// File: rtl/register_file_rename_rf_read_port.sv
// Operand lookup for one source register, with same-cycle commit bypass.
// Latency: purely combinational, zero cycles.
// Backpressure: none; outputs always reflect the inputs.
// Ports: addr_i selects the register; ent_*_i is that register's stored
//        value/busy/tag; commit_*_i is the ROB commit bus; *_o is the operand.
module rf_read_port
    import register_file_rename_pkg::*;
#(
    parameter int TAG_W = ROB_WIDTH
) (
    input  logic [REG_IDX_W-1:0] addr_i,
    input  logic [XLEN-1:0]      ent_value_i,
    input  logic                 ent_busy_i,
    input  logic [TAG_W-1:0]     ent_tag_i,
    input  logic                 commit_done_i,
    input  logic [XLEN-1:0]      commit_value_i,
    input  logic [TAG_W-1:0]     commit_tag_i,
    output logic                 busy_o,
    output logic [XLEN-1:0]      value_o,
    output logic [TAG_W-1:0]     tag_o
);

    always_comb begin
        busy_o  = ent_busy_i;
        value_o = ent_value_i;
        tag_o   = ent_tag_i;
        if (addr_i == '0) begin
            busy_o  = 1'b0;
            value_o = '0;
            tag_o   = '0;
        end else if (ent_busy_i && commit_done_i && (ent_tag_i == commit_tag_i)) begin
            // The pending producer is committing right now: hand its value
            // straight to the consumer instead of waiting a cycle.
            busy_o  = 1'b0;
            value_o = commit_value_i;
        end
    end

endmodule

// File: rtl/register_file_rename.sv
// Architectural register file with per-register ROB rename tags.
// Latency: reads combinational (pre-update state); issue/commit/flush update state next edge.
// Backpressure: rdy_in low freezes all state; reads stay live on current state.
// Ports: clk_in/rst_in (sync active-high); rdy_in stall; clear_signal flush;
//        issue_* rename of a new destination; commit_* ROB register commit bus;
//        rs1_*/rs2_* source operand lookups (value or pending producer tag).
module register_file_rename
    import register_file_rename_pkg::*;
#(
    parameter int ROB_WIDTH = register_file_rename_pkg::ROB_WIDTH,
    parameter int REG_COUNT = register_file_rename_pkg::REG_COUNT
) (
    input  logic                 clk_in,
    input  logic                 rst_in,
    input  logic                 rdy_in,
    input  logic                 clear_signal,
    input  logic                 issue_signal,
    input  logic [4:0]           issue_rd,
    input  logic [ROB_WIDTH-1:0] issue_tag,
    input  logic                 commit_done,
    input  logic [31:0]          commit_value,
    input  logic [ROB_WIDTH-1:0] commit_tag,
    input  logic [4:0]           rs1_addr,
    output logic                 rs1_busy,
    output logic [31:0]          rs1_value,
    output logic [ROB_WIDTH-1:0] rs1_tag,
    input  logic [4:0]           rs2_addr,
    output logic                 rs2_busy,
    output logic [31:0]          rs2_value,
    output logic [ROB_WIDTH-1:0] rs2_tag
);

    localparam int TAG_COUNT = 1 << ROB_WIDTH;

    word_t                regs_q      [REG_COUNT];
    word_t                regs_d      [REG_COUNT];
    logic                 busy_q      [REG_COUNT];
    logic                 busy_d      [REG_COUNT];
    logic [ROB_WIDTH-1:0] tag_q       [REG_COUNT];
    logic [ROB_WIDTH-1:0] tag_d       [REG_COUNT];
    reg_idx_t             rd_of_tag_q [TAG_COUNT];
    reg_idx_t             rd_of_tag_d [TAG_COUNT];

    reg_idx_t commit_rd;
    assign commit_rd = rd_of_tag_q[commit_tag];

    // Update order matters: commit first, then flush clears every busy bit,
    // then a (non-flushed) issue re-marks its destination busy so a rename in
    // the same cycle as the older producer's commit keeps the register pending.
    always_comb begin
        regs_d      = regs_q;
        busy_d      = busy_q;
        tag_d       = tag_q;
        rd_of_tag_d = rd_of_tag_q;
        if (rdy_in) begin
            if (commit_done && (commit_rd != '0)) begin
                regs_d[commit_rd] = commit_value;
                if (busy_q[commit_rd] && (tag_q[commit_rd] == commit_tag)) begin
                    busy_d[commit_rd] = 1'b0;
                end
            end
            if (clear_signal) begin
                for (int i = 0; i < REG_COUNT; i++) begin
                    busy_d[i] = 1'b0;
                end
            end else if (issue_signal) begin
                // rd 0 is still recorded so a later commit of this tag writes nothing.
                rd_of_tag_d[issue_tag] = issue_rd;
                if (issue_rd != '0) begin
                    busy_d[issue_rd] = 1'b1;
                    tag_d[issue_rd]  = issue_tag;
                end
            end
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            regs_q      <= '{default: '0};
            busy_q      <= '{default: 1'b0};
            tag_q       <= '{default: '0};
            rd_of_tag_q <= '{default: '0};
        end else begin
            regs_q      <= regs_d;
            busy_q      <= busy_d;
            tag_q       <= tag_d;
            rd_of_tag_q <= rd_of_tag_d;
        end
    end

    rf_read_port #(.TAG_W(ROB_WIDTH)) u_rs1 (
        .addr_i         (rs1_addr),
        .ent_value_i    (regs_q[rs1_addr]),
        .ent_busy_i     (busy_q[rs1_addr]),
        .ent_tag_i      (tag_q[rs1_addr]),
        .commit_done_i  (commit_done),
        .commit_value_i (commit_value),
        .commit_tag_i   (commit_tag),
        .busy_o         (rs1_busy),
        .value_o        (rs1_value),
        .tag_o          (rs1_tag)
    );

    rf_read_port #(.TAG_W(ROB_WIDTH)) u_rs2 (
        .addr_i         (rs2_addr),
        .ent_value_i    (regs_q[rs2_addr]),
        .ent_busy_i     (busy_q[rs2_addr]),
        .ent_tag_i      (tag_q[rs2_addr]),
        .commit_done_i  (commit_done),
        .commit_value_i (commit_value),
        .commit_tag_i   (commit_tag),
        .busy_o         (rs2_busy),
        .value_o        (rs2_value),
        .tag_o          (rs2_tag)
    );

endmodule

// File: tb/tb_register_file_rename.sv
// Bench for register_file_rename: directed scenarios then randomized ROB-like traffic.
// Latency: checks reads combinationally each cycle against a reference model.
// Backpressure: exercises rdy_in stalls and flushes.
module tb_register_file_rename;

    logic        clk_in = 1'b0;
    logic        rst_in, rdy_in, clear_signal, issue_signal, commit_done;
    logic [4:0]  issue_rd, rs1_addr, rs2_addr;
    logic [3:0]  issue_tag, commit_tag, rs1_tag, rs2_tag;
    logic [31:0] commit_value, rs1_value, rs2_value;
    logic        rs1_busy, rs2_busy;

    always #5 clk_in = ~clk_in;

    register_file_rename dut (
        .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .clear_signal(clear_signal),
        .issue_signal(issue_signal), .issue_rd(issue_rd), .issue_tag(issue_tag),
        .commit_done(commit_done), .commit_value(commit_value), .commit_tag(commit_tag),
        .rs1_addr(rs1_addr), .rs1_busy(rs1_busy), .rs1_value(rs1_value), .rs1_tag(rs1_tag),
        .rs2_addr(rs2_addr), .rs2_busy(rs2_busy), .rs2_value(rs2_value), .rs2_tag(rs2_tag)
    );

    // Reference model: architectural state as plain arrays, updated by the rules.
    logic [31:0] m_regs [32];
    bit          m_busy [32];
    int          m_tag  [32];
    int          m_dest [16];
    int          passed = 0;
    int          total  = 0;
    int          rob_q[$];

    task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%h expected=%h", name, obs, exp);
    endtask

    task automatic model_reset();
        for (int i = 0; i < 32; i++) begin
            m_regs[i] = 0; m_busy[i] = 0; m_tag[i] = 0;
        end
        for (int i = 0; i < 16; i++) m_dest[i] = 0;
    endtask

    task automatic model_step();
        int r;
        if (rst_in) begin
            model_reset();
        end else if (rdy_in) begin
            if (commit_done) begin
                r = m_dest[commit_tag];
                if (r != 0) begin
                    m_regs[r] = commit_value;
                    if (m_busy[r] && m_tag[r] == int'(commit_tag)) m_busy[r] = 0;
                end
            end
            if (clear_signal) begin
                for (int i = 0; i < 32; i++) m_busy[i] = 0;
            end else if (issue_signal) begin
                m_dest[issue_tag] = int'(issue_rd);
                if (issue_rd != 0) begin
                    m_busy[issue_rd] = 1;
                    m_tag[issue_rd]  = int'(issue_tag);
                end
            end
        end
    endtask

    task automatic expect_read(input logic [4:0] a, output logic [31:0] v, output logic b,
                               output logic [3:0] t);
        if (a == 0) begin
            v = 0; b = 0; t = 0;
        end else begin
            v = m_regs[a]; b = m_busy[a]; t = 4'(m_tag[a]);
            if (m_busy[a] && commit_done && m_tag[a] == int'(commit_tag)) begin
                v = commit_value; b = 0;
            end
        end
    endtask

    // Let inputs settle, then compare both ports against the model.
    task automatic settle();
        logic [31:0] v; logic b; logic [3:0] t;
        #2;
        expect_read(rs1_addr, v, b, t);
        chk("rs1_value", rs1_value, v);
        chk("rs1_busy", 32'(rs1_busy), 32'(b));
        chk("rs1_tag", 32'(rs1_tag), 32'(t));
        expect_read(rs2_addr, v, b, t);
        chk("rs2_value", rs2_value, v);
        chk("rs2_busy", 32'(rs2_busy), 32'(b));
        chk("rs2_tag", 32'(rs2_tag), 32'(t));
    endtask

    task automatic advance();
        @(posedge clk_in);
        model_step();
        #1;
    endtask

    task automatic idle();
        rdy_in = 1; clear_signal = 0; issue_signal = 0; issue_rd = 0; issue_tag = 0;
        commit_done = 0; commit_value = 0; commit_tag = 0;
    endtask

    task automatic issue(input logic [4:0] rd, input logic [3:0] t);
        idle(); issue_signal = 1; issue_rd = rd; issue_tag = t;
    endtask

    task automatic do_reset();
        idle(); rst_in = 1;
        @(posedge clk_in); @(posedge clk_in);
        model_step();
        #1; rst_in = 0;
    endtask

    function automatic bit tag_used(input int t);
        foreach (rob_q[i]) if (rob_q[i] == t) return 1;
        return 0;
    endfunction

    initial begin
        rs1_addr = 0; rs2_addr = 0;
        do_reset();

        // Reset state
        rs1_addr = 5; rs2_addr = 0; settle();
        chk("reset_rs1_value", rs1_value, 0);
        chk("reset_rs1_busy", 32'(rs1_busy), 0);
        chk("reset_rs1_tag", 32'(rs1_tag), 0);
        chk("reset_rs2_value", rs2_value, 0);
        chk("reset_rs2_busy", 32'(rs2_busy), 0);
        advance();

        // Rename then commit with bypass
        issue(3, 2); settle(); advance();
        idle(); rs1_addr = 3; settle();
        chk("rename_busy", 32'(rs1_busy), 1); chk("rename_tag", 32'(rs1_tag), 2); advance();
        commit_done = 1; commit_tag = 2; commit_value = 32'h1234; settle();
        chk("bypass_busy", 32'(rs1_busy), 0); chk("bypass_value", rs1_value, 32'h1234); advance();
        idle(); settle();
        chk("committed_value", rs1_value, 32'h1234); chk("committed_busy", 32'(rs1_busy), 0);
        advance();

        // Rename chain on x7
        issue(7, 1); settle(); advance();
        issue(7, 4); settle(); advance();
        idle(); commit_done = 1; commit_tag = 1; commit_value = 32'hAA; rs1_addr = 7; settle();
        advance();
        idle(); settle();
        chk("chain_still_busy", 32'(rs1_busy), 1); chk("chain_new_tag", 32'(rs1_tag), 4);
        advance();
        commit_done = 1; commit_tag = 4; commit_value = 32'hBB; settle(); advance();
        idle(); settle();
        chk("chain_done_busy", 32'(rs1_busy), 0); chk("chain_done_value", rs1_value, 32'hBB);
        advance();

        // Same-cycle commit and issue on x9
        issue(9, 5); settle(); advance();
        issue(9, 6); commit_done = 1; commit_tag = 5; commit_value = 32'h55; settle(); advance();
        idle(); rs1_addr = 9; settle();
        chk("same_value", rs1_value, 32'h55); chk("same_busy", 32'(rs1_busy), 1);
        chk("same_tag", 32'(rs1_tag), 6);
        advance();

        // Flush with concurrent commit and dropped issue
        issue(4, 0); settle(); advance();
        issue(6, 1); settle(); advance();
        issue(8, 2); clear_signal = 1; commit_done = 1; commit_tag = 0; commit_value = 32'h10;
        settle(); advance();
        idle(); rs1_addr = 4; rs2_addr = 6; settle();
        chk("flush_x4_value", rs1_value, 32'h10); chk("flush_x4_busy", 32'(rs1_busy), 0);
        chk("flush_x6_busy", 32'(rs2_busy), 0);
        advance();
        rs1_addr = 8; settle(); chk("flush_x8_busy", 32'(rs1_busy), 0); advance();

        // x0 never written or busy
        issue(0, 3); rs1_addr = 0; settle(); advance();
        idle(); commit_done = 1; commit_tag = 3; commit_value = 32'hFF; settle(); advance();
        idle(); settle();
        chk("x0_value", rs1_value, 0); chk("x0_busy", 32'(rs1_busy), 0);
        advance();

        // Stall: issue ignored while rdy_in low
        issue(2, 7); rdy_in = 0; rs1_addr = 2; settle(); advance();
        idle(); settle(); chk("stall_busy", 32'(rs1_busy), 0); advance();

        // Randomized ROB-like traffic
        do_reset();
        rob_q.delete();
        for (int c = 0; c < 600; c++) begin
            bit want_issue;
            int t;
            idle();
            rdy_in       = ($urandom % 8) != 0;
            clear_signal = ($urandom % 24) == 0;
            commit_value = $urandom;
            commit_done  = (rob_q.size() > 0) && ($urandom % 2 == 1);
            commit_tag   = commit_done ? 4'(rob_q[0]) : 4'($urandom);
            want_issue   = (rob_q.size() < 16) && ($urandom % 3 != 0);
            if (want_issue) begin
                t = $urandom % 16;
                while (tag_used(t)) t = (t + 1) % 16;
                issue_signal = 1;
                issue_tag    = 4'(t);
                issue_rd     = ($urandom % 5 == 0) ? 5'd0 : 5'($urandom % 8);
            end
            rs1_addr = 5'($urandom % 8);
            rs2_addr = 5'($urandom % 8);
            settle();
            advance();
            if (rdy_in) begin
                if (commit_done) void'(rob_q.pop_front());
                if (clear_signal) rob_q.delete();
                else if (issue_signal) rob_q.push_back(int'(issue_tag));
            end
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
